// File: rtl/kw_ram_1rws_stream_ctrl_if.sv
// +-----------------------------------------------------------------------------+
// | kw_ram_1rws_stream_ctrl_if                                                  |
// | Request, response and RAM pin bundle for kw_ram_1rws_stream_ctrl.           |
// | Optional: KW_RAM_1RWS_STREAM_CTRL_WACK_EN adds rsp_is_write.                |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface kw_ram_1rws_stream_ctrl_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
`ifdef KW_RAM_1RWS_STREAM_CTRL_WACK_EN
    logic                  rsp_is_write;
`endif

    logic                  ram_cs_n;
    logic                  ram_we_n;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, ram_cs_n, ram_we_n, ram_addr, ram_wdata
`ifdef KW_RAM_1RWS_STREAM_CTRL_WACK_EN
        , output rsp_is_write
`endif
    );

    // Requester / consumer / RAM side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, ram_cs_n, ram_we_n, ram_addr, ram_wdata
`ifdef KW_RAM_1RWS_STREAM_CTRL_WACK_EN
        , input rsp_is_write
`endif
    );
endinterface

`default_nettype wire

// File: rtl/kw_ram_1rws_stream_ctrl.sv
// +-----------------------------------------------------------------------------+
// | kw_ram_1rws_stream_ctrl                                                     |
// | Valid/ready front end for a 1RW DFF RAM with a credit-protected response    |
// | FIFO. Optional: KW_RAM_1RWS_STREAM_CTRL_WACK_EN (write acknowledgements).   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module kw_ram_1rws_stream_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 32,
    parameter int RSP_DEPTH  = 4
) (
    input  wire logic                 clock,
    input  wire logic                 reset_n,
    kw_ram_1rws_stream_ctrl_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_W      = $clog2(RSP_DEPTH);
    localparam int USED_W     = $clog2(RSP_DEPTH + 1);

    localparam logic [USED_W-1:0] CREDITS  = USED_W'(RSP_DEPTH);
    localparam logic [USED_W-1:0] USED_ONE = USED_W'(1);
    localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);

    logic                  accept;
    logic                  take_credit;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [USED_W-1:0]     used;
    logic                  rd_pend;
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic [PTR_W-1:0]      wr_idx;
    logic [PTR_W-1:0]      rd_idx;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];

    assign req_addr      = bus.req_addr;

    // Credits gate both request types, so a full FIFO stalls writes too.
    assign bus.req_ready = reset_n && (used < CREDITS);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.ram_cs_n  = !accept;
    assign bus.ram_we_n  = !(accept && bus.req_we);
    assign bus.ram_addr  = req_addr;
    assign bus.ram_wdata = bus.req_wdata;

    assign wr_idx     = wr_ptr[PTR_W-1:0];
    assign rd_idx     = rd_ptr[PTR_W-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);

    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign push          = rd_pend;
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_rdata = fifo_empty ? '0 : fifo_data[rd_idx];

`ifdef KW_RAM_1RWS_STREAM_CTRL_WACK_EN
    logic pend_is_write;
    logic fifo_is_write [RSP_DEPTH];

    assign take_credit      = accept;
    assign push_data        = pend_is_write ? '0 : bus.ram_rdata;
    assign bus.rsp_is_write = fifo_empty ? 1'b0 : fifo_is_write[rd_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_is_write <= 1'b0;
        end else begin
            pend_is_write <= accept && bus.req_we;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_is_write[wr_idx] <= pend_is_write;
        end
    end
`else
    assign take_credit = accept && !bus.req_we;
    assign push_data   = bus.ram_rdata;
`endif

    // Credit counter: accepted-but-unpopped responses, including in-flight reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            used <= '0;
        end else if (take_credit && !pop) begin
            used <= used + USED_ONE;
        end else if (!take_credit && pop) begin
            used <= used - USED_ONE;
        end
    end

    // ram_rdata is valid exactly one cycle after the access that earns a credit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= take_credit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_idx] <= push_data;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && fifo_full));
`endif

endmodule

`default_nettype wire

// File: doc/kw_ram_1rws_stream_ctrl.md
# kw_ram_1rws_stream_ctrl

Valid/ready front end for the single-port synchronous DFF RAM (1RW, active-low `cs_n`/`we_n`, one-cycle read latency). It turns a stream of read and write requests into RAM pin activity. It also captures each read's `data_out` into a credit-protected response FIFO, so a stalled consumer never loses data. The block sits directly upstream of the RAM and drives its `cs_n`, `we_n`, `rw_addr` and `data_in` pins one-to-one.

## Interface
- `DATA_WIDTH`, 256: request write data, RAM data and response data width.
- `DEPTH`, 32: RAM words; `ADDR_WIDTH = $clog2(DEPTH)`.
- `RSP_DEPTH`, 4: response FIFO entries and read credits. Must be a power of two and ≥2; ≥3 gives one read per cycle.
- `clock` in 1: single clock; all state on the rising edge.
- `reset_n` in 1: asynchronous assert, active-low; deassertion is synchronous to `clock` upstream.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_WIDTH`: word address.
- `req_wdata` in `DATA_WIDTH`: write data; ignored for reads.
- `rsp_valid` out 1: response at FIFO head.
- `rsp_ready` in 1: consumer pops when `rsp_valid && rsp_ready`.
- `rsp_rdata` out `DATA_WIDTH`: read data, in request order.
- `ram_cs_n` out 1: to RAM `cs_n`.
- `ram_we_n` out 1: to RAM `we_n`.
- `ram_addr` out `ADDR_WIDTH`: to RAM `rw_addr`.
- `ram_wdata` out `DATA_WIDTH`: to RAM `data_in`.
- `ram_rdata` in `DATA_WIDTH`: from RAM `data_out`; valid only in the cycle after a read access.

## Operation
- Credit counter `used` (0..RSP_DEPTH) counts reads accepted but not yet popped.
- `used` increments on read accept and decrements on pop. Both in one cycle leave it unchanged.
- `req_ready = reset_n && (used < RSP_DEPTH)` for both request types. There is no combinational path from `rsp_ready`.
- RAM pins are combinational from the accepted request:
  - `ram_cs_n = !(req_valid && req_ready)`.
  - `ram_we_n = !(req_we && req_valid && req_ready)`.
  - `ram_addr = req_addr`.
  - `ram_wdata = req_wdata`.
- Registered flag `rd_pend` is set on a read accept. In the following cycle, `ram_rdata` is written into the FIFO tail.
- Because of the credit check, the FIFO can never overflow. A FIFO write with the FIFO full is an assertion error.
- Writes consume no credit and produce no response, except with the macro below.
- Requests are issued to the RAM in accept order; responses return in read order.
- A read following a write to the same address returns the new data. This includes a read in the very next cycle.

## Timing
- Reset values:
  - `req_ready` = 0 while `reset_n` = 0, then 1.
  - `ram_cs_n` = 1 and `ram_we_n` = 1 during reset.
  - `rsp_valid` = 0; `rsp_rdata` = 0.
  - `used` = 0; `rd_pend` = 0; FIFO pointers = 0.
- Read latency: accept in cycle N; RAM returns data in N+1; `rsp_valid` is high in N+2. Earliest pop is N+2.
- Write takes effect at the rising edge ending the accept cycle.
- Back-to-back reads at one per cycle, with `rsp_ready` held high, need RSP_DEPTH ≥ 3.
- `rsp_valid`/`rsp_rdata` hold stable until popped.
- Boundaries:
  - `used == RSP_DEPTH` drops `req_ready` the same cycle, for reads and writes alike.
  - A pop in a full cycle raises `req_ready` the next cycle.
  - FIFO pointers wrap modulo RSP_DEPTH.
  - Reset mid-operation discards any in-flight read and all buffered responses. No response is emitted for requests accepted before reset.

## Configuration
- `KW_RAM_1RWS_STREAM_CTRL_WACK_EN` defined:
  - Every accepted write also consumes a credit and pushes a response entry one cycle after accept, with `rsp_rdata` = 0.
  - Output `rsp_is_write` (1 bit, reset 0) flags these entries.
  - Ordering across reads and writes is preserved.
- Undefined: writes produce no response, do not touch `used`, and the `rsp_is_write` port is absent.

## Test plan
- Reset: hold `reset_n` low with `req_valid`=1 -> `ram_cs_n`=1, `req_ready`=0, `rsp_valid`=0. After release, `req_ready`=1.
- Write 0xA5.. to addr 3, then read addr 3 the next cycle -> `rsp_valid` two cycles after the read accept, `rsp_rdata`=0xA5...
- Streaming: reads of addr 0..31 with `rsp_ready`=1 and RSP_DEPTH=4 -> one accept per cycle and 32 in-order responses.
- Backpressure: `rsp_ready`=0 with 6 reads offered -> exactly 4 accepted, then `req_ready`=0. One pop -> one more accept. All data correct.
- Reset mid-flight: assert `reset_n` low with 3 responses buffered and 1 read pending -> after release, `rsp_valid` stays 0 and `used`=0.
- WACK_EN: interleaved W,R,W -> responses in order with `rsp_is_write`=1,0,1 and write `rsp_rdata`=0.
